// File: rtl/block_interleaver.sv
// Ping-pong ROWS x COLS block interleaver/deinterleaver with a runtime mode per block.
// Optional INTERLEAVER_FLUSH_EN adds i_flush/o_busy to zero-pad a partial block.
module block_interleaver #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned ROWS  = 4,
   parameter int unsigned COLS  = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_mode,
   input  logic             i_in_valid,
   input  logic [WIDTH-1:0] i_in_data,
   output logic             o_in_ready,
   output logic             o_out_valid,
   output logic [WIDTH-1:0] o_out_data,
   output logic             o_out_last,
`ifdef INTERLEAVER_FLUSH_EN
   input  logic             i_flush,
   output logic             o_busy,
`endif
   output logic             o_overflow
);

   localparam int unsigned N  = ROWS * COLS;
   localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [AW-1:0] KLast  = AW'(N - 1);
   localparam logic [AW-1:0] ColsA  = AW'(COLS);
   localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);

   typedef enum logic {StIdle, StRead} rd_state_e;

   logic [WIDTH-1:0] r_mem0 [N];
   logic [WIDTH-1:0] r_mem1 [N];
   logic [1:0]       r_full, w_full_d;
   logic [1:0]       r_bank_mode;
   logic             r_wb, r_rb;
   logic [AW-1:0]    r_wk, r_rj;
   logic [RW-1:0]    r_wrow, r_rrow;
   logic [CW-1:0]    r_wcol, r_rcol;
   rd_state_e        r_state, w_state_d;
   logic             r_rd_valid, r_rd_last;
   logic [WIDTH-1:0] r_rd_data;
   logic             r_out_valid, r_out_last, r_overflow;
   logic [WIDTH-1:0] r_out_data;

   logic             w_accept, w_wr_en, w_wlast, w_wmode, w_rd_issue, w_rlast;
   logic [WIDTH-1:0] w_wr_data, w_rd_data;
   logic [AW-1:0]    w_wperm, w_rperm, w_waddr, w_raddr;

   assign w_accept = i_in_valid & o_in_ready;

`ifdef INTERLEAVER_FLUSH_EN
   logic r_pad;
   assign o_in_ready = ~r_full[r_wb] & ~r_pad;
   assign o_busy     = r_pad;
   assign w_wr_en    = w_accept | r_pad;
   assign w_wr_data  = r_pad ? '0 : i_in_data;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pad <= 1'b0;
      end else if (r_pad) begin
         if (w_wlast) r_pad <= 1'b0;
      end else if (i_flush && (r_wk != '0) && !(w_accept && w_wlast)) begin
         r_pad <= 1'b1;
      end
   end
`else
   assign o_in_ready = ~r_full[r_wb];
   assign w_wr_en    = w_accept;
   assign w_wr_data  = i_in_data;
`endif

   // Row-major position of column-order index k: (k mod ROWS)*COLS + (k div ROWS)
   assign w_wperm = AW'(r_wrow) * ColsA + AW'(r_wcol);
   assign w_rperm = AW'(r_rrow) * ColsA + AW'(r_rcol);
   assign w_wlast = (r_wk == KLast);
   assign w_rlast = (r_rj == KLast);
   assign w_wmode = (r_wk == '0) ? i_mode : r_bank_mode[r_wb];
   assign w_waddr = w_wmode ? w_wperm : r_wk;
   assign w_raddr = r_bank_mode[r_rb] ? r_rj : w_rperm;
   assign w_rd_issue = (r_state == StRead) | r_full[r_rb];
   assign w_rd_data  = r_rb ? r_mem1[w_raddr] : r_mem0[w_raddr];

   always_comb begin
      w_full_d = r_full;
      if (w_wr_en && w_wlast) w_full_d[r_wb] = 1'b1;
      if (w_rd_issue && w_rlast) w_full_d[r_rb] = 1'b0;
   end

   always_comb begin
      w_state_d = r_state;
      if (w_rd_issue) begin
         w_state_d = (w_rlast && !w_full_d[~r_rb]) ? StIdle : StRead;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         if (r_wb) r_mem1[w_waddr] <= w_wr_data;
         else      r_mem0[w_waddr] <= w_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_full      <= 2'b00;
         r_bank_mode <= 2'b00;
         r_wb        <= 1'b0;
         r_wk        <= '0;
         r_wrow      <= '0;
         r_wcol      <= '0;
         r_overflow  <= 1'b0;
      end else begin
         r_full <= w_full_d;
         if (i_in_valid && !o_in_ready) r_overflow <= 1'b1;
         if (w_accept && (r_wk == '0)) r_bank_mode[r_wb] <= i_mode;
         if (w_wr_en) begin
            if (w_wlast) begin
               r_wk   <= '0;
               r_wrow <= '0;
               r_wcol <= '0;
               r_wb   <= ~r_wb;
            end else begin
               r_wk <= r_wk + AW'(1);
               if (r_wrow == RowLast) begin
                  r_wrow <= '0;
                  r_wcol <= r_wcol + CW'(1);
               end else begin
                  r_wrow <= r_wrow + RW'(1);
               end
            end
         end
      end
   end

   // Two-stage read path: memory capture, then output register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_rb        <= 1'b0;
         r_rj        <= '0;
         r_rrow      <= '0;
         r_rcol      <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
         r_rd_data   <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_state    <= w_state_d;
         r_rd_valid <= w_rd_issue;
         r_rd_last  <= w_rd_issue & w_rlast;
         if (w_rd_issue) begin
            r_rd_data <= w_rd_data;
            if (w_rlast) begin
               r_rj   <= '0;
               r_rrow <= '0;
               r_rcol <= '0;
               r_rb   <= ~r_rb;
            end else begin
               r_rj <= r_rj + AW'(1);
               if (r_rrow == RowLast) begin
                  r_rrow <= '0;
                  r_rcol <= r_rcol + CW'(1);
               end else begin
                  r_rrow <= r_rrow + RW'(1);
               end
            end
         end
         r_out_valid <= r_rd_valid;
         r_out_last  <= r_rd_valid & r_rd_last;
         if (r_rd_valid) r_out_data <= r_rd_data;
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_last  = r_out_last;
   assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_block_interleaver.sv
// Scoreboard bench for block_interleaver, 8-bit symbols in 2x3 blocks.
// Define INTERLEAVER_FLUSH_EN to also exercise the flush/busy path.
module tb_block_interleaver;

   logic       clk = 1'b0;
   logic       reset, mode, in_valid, in_ready, out_valid, out_last, overflow;
   logic [7:0] in_data, out_data;
`ifdef INTERLEAVER_FLUSH_EN
   logic       flush, busy;
`endif

   int n_pass = 0;
   int n_total = 0;
   logic [8:0] exp_q[$];
   logic mon_en = 1'b1;
   string cur = "init";

   // Hand-derived orderings for a 2x3 block: out[j] = in[ILV[j]] / in[DIL[j]]
   int ilv[6] = '{0, 3, 1, 4, 2, 5};
   int dil[6] = '{0, 2, 4, 1, 3, 5};

   always #5 clk = ~clk;

   block_interleaver #(.WIDTH(8), .ROWS(2), .COLS(3)) dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_mode     (mode),
      .i_in_valid (in_valid),
      .i_in_data  (in_data),
      .o_in_ready (in_ready),
      .o_out_valid(out_valid),
      .o_out_data (out_data),
      .o_out_last (out_last),
`ifdef INTERLEAVER_FLUSH_EN
      .i_flush    (flush),
      .o_busy     (busy),
`endif
      .o_overflow (overflow)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s/%s: got %0h expected %0h", cur, name, act, exp);
   endtask

   always @(negedge clk) begin
      if (mon_en && !reset && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_data), 32'hFFFF);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e[7:0]));
            check("out_last", 32'(out_last), 32'(e[8]));
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic m, input logic chk_rdy);
      mode = m;
      in_valid = 1'b1;
      in_data = d;
      if (chk_rdy) check("in_ready_high", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   // Push the expected output of a block given its 6 inputs and mode
   task automatic expect_block(input logic [7:0] blk [6], input logic m);
      for (int j = 0; j < 6; j++) begin
         exp_q.push_back({(j == 5), blk[m ? dil[j] : ilv[j]]});
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("drained", 32'(exp_q.size()), 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] blk [6];
      reset = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0;
`ifdef INTERLEAVER_FLUSH_EN
      flush = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      cur = "reset";
      check("in_ready", 32'(in_ready), 32'd1);
      check("out_valid", 32'(out_valid), 32'd0);
      check("out_data", 32'(out_data), 32'd0);
      check("out_last", 32'(out_last), 32'd0);
      check("overflow", 32'(overflow), 32'd0);

      // 1: interleave 0..5 and check the two-cycle latency
      cur = "t1_interleave";
      blk = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
      exp_q.push_back({1'b0, 8'd0}); exp_q.push_back({1'b0, 8'd3});
      exp_q.push_back({1'b0, 8'd1}); exp_q.push_back({1'b0, 8'd4});
      exp_q.push_back({1'b0, 8'd2}); exp_q.push_back({1'b1, 8'd5});
      for (int i = 0; i < 6; i++) send(blk[i], 1'b0, 1'b1);
      in_valid = 1'b0;
      check("valid_T0", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("valid_T1", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("valid_T2", 32'(out_valid), 32'd1);
      drain();

      // 2: deinterleave restores natural order
      cur = "t2_deinterleave";
      blk = '{8'd0, 8'd3, 8'd1, 8'd4, 8'd2, 8'd5};
      for (int j = 0; j < 6; j++) exp_q.push_back({(j == 5), 8'(j)});
      for (int i = 0; i < 6; i++) send(blk[i], 1'b1, 1'b1);
      in_valid = 1'b0;
      drain();

      // 3: four back-to-back blocks, alternating mode
      cur = "t3_stream";
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 6; i++) blk[i] = 8'(16 * (b + 1) + i);
         expect_block(blk, b[0]);
      end
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 6; i++) send(8'(16 * (b + 1) + i), b[0], 1'b1);
      end
      in_valid = 1'b0;
      drain();
      check("overflow_clear", 32'(overflow), 32'd0);

      // 5: reset mid-block discards the partial block
      cur = "t5_reset_mid";
      for (int i = 0; i < 3; i++) send(8'(7 + i), 1'b0, 1'b0);
      do_reset();
      blk = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
      exp_q.push_back({1'b0, 8'd10}); exp_q.push_back({1'b0, 8'd13});
      exp_q.push_back({1'b0, 8'd11}); exp_q.push_back({1'b0, 8'd14});
      exp_q.push_back({1'b0, 8'd12}); exp_q.push_back({1'b1, 8'd15});
      for (int i = 0; i < 6; i++) send(blk[i], 1'b0, 1'b1);
      in_valid = 1'b0;
      drain();

      // 4: both banks forced full, a write is dropped and overflow sticks
      cur = "t4_overflow";
      mon_en = 1'b0;
      force dut.r_full = 2'b11;
      #1;
      check("in_ready_low", 32'(in_ready), 32'd0);
      in_valid = 1'b1; in_data = 8'hAA;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("overflow_set", 32'(overflow), 32'd1);
      release dut.r_full;
      repeat (10) @(posedge clk);
      #1;
      check("overflow_sticky", 32'(overflow), 32'd1);
      do_reset();
      check("overflow_after_reset", 32'(overflow), 32'd0);
      check("ready_after_reset", 32'(in_ready), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      check("quiet_after_reset", 32'(out_valid), 32'd0);
      mon_en = 1'b1;

`ifdef INTERLEAVER_FLUSH_EN
      // 6: partial block 1..4 padded with zeros by flush
      cur = "t6_flush";
      exp_q.push_back({1'b0, 8'd1}); exp_q.push_back({1'b0, 8'd4});
      exp_q.push_back({1'b0, 8'd2}); exp_q.push_back({1'b0, 8'd0});
      exp_q.push_back({1'b0, 8'd3}); exp_q.push_back({1'b1, 8'd0});
      for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0, 1'b1);
      in_valid = 1'b0;
      flush = 1'b1;
      check("busy_before", 32'(busy), 32'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      check("busy_1", 32'(busy), 32'd1);
      check("ready_pad", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      check("busy_2", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("busy_done", 32'(busy), 32'd0);
      drain();
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
